instruction_timing_sequencer: RTL

- Parametrised successor to the free-running 7-state T-counter in the 6502 decode path.
- Latches the opcode in the fetch cycle and decodes addressing mode and operation class from the aaabbbcc fields.
- Derives the instruction length in cycles and runs T-states T0..Tn-1 instead of a fixed T0..T6 loop.
- Handles RDY stalls, page-cross and branch penalty cycles, and drives rw/sync/last_cycle for the datapath and bus.

---
 rtl/instruction_timing_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_timing_sequencer.sv
// rtl/instruction_timing_sequencer.sv - variable-length 6502 T-state sequencer; optional macro PAGE_CROSS_EN
module instruction_timing_sequencer #(
    parameter int T_WIDTH          = 3,
    parameter int RDY_STALL_WRITES = 0
) (
    input  logic               clk,
    input  logic               res,
    input  logic               rdy,
    input  logic [7:0]         instruction,
    input  logic               page_cross,
    input  logic               branch_taken,
    output logic [T_WIDTH-1:0] t_state,
    output logic               sync,
    output logic [7:0]         opcode,
    output logic [3:0]         addr_mode,
    output logic [1:0]         op_class,
    output logic               rw,
    output logic               last_cycle
);
    localparam logic [3:0] M_IMP = 4'd0, M_IMM = 4'd1, M_ZPG = 4'd2, M_ZPX = 4'd3,
                           M_ZPY = 4'd4, M_ABS = 4'd5, M_ABX = 4'd6, M_ABY = 4'd7,
                           M_IZX = 4'd8, M_IZY = 4'd9, M_REL = 4'd10, M_STK = 4'd11;
    localparam logic [1:0] C_READ = 2'd0, C_STORE = 2'd1, C_RMW = 2'd2, C_CTRL = 2'd3;

    logic [2:0] aaa, bbb;
    logic [1:0] cc;
    logic [3:0] dec_mode;
    logic [1:0] dec_cls;
    logic [2:0] dec_len, len_q, len_eff, len_n;
    logic       special, penalty, pc_eff, stall;
    logic [T_WIDTH-1:0] t_n;
    logic [7:0] opcode_n;
    logic [3:0] mode_n;
    logic [1:0] cls_n;

    assign aaa = instruction[7:5];
    assign bbb = instruction[4:2];
    assign cc  = instruction[1:0];

`ifdef PAGE_CROSS_EN
    assign pc_eff = page_cross;
`else
    assign pc_eff = 1'b1;
`endif

    // Opcode decode, only meaningful while t_state is T0.
    always_comb begin
        dec_mode = M_IMP;
        case (cc)
            2'b01: case (bbb)
                3'd0: dec_mode = M_IZX;
                3'd1: dec_mode = M_ZPG;
                3'd2: dec_mode = M_IMM;
                3'd3: dec_mode = M_ABS;
                3'd4: dec_mode = M_IZY;
                3'd5: dec_mode = M_ZPX;
                3'd6: dec_mode = M_ABY;
                default: dec_mode = M_ABX;
            endcase
            2'b10: case (bbb)
                3'd0: dec_mode = M_IMM;
                3'd1: dec_mode = M_ZPG;
                3'd3: dec_mode = M_ABS;
                3'd5: dec_mode = (aaa == 3'd4 || aaa == 3'd5) ? M_ZPY : M_ZPX;
                3'd7: dec_mode = (aaa == 3'd5) ? M_ABY : M_ABX;
                default: dec_mode = M_IMP;
            endcase
            2'b00: case (bbb)
                3'd0: dec_mode = (aaa >= 3'd5) ? M_IMM : M_IMP;
                3'd1: dec_mode = M_ZPG;
                3'd3: dec_mode = M_ABS;
                3'd4: dec_mode = M_REL;
                3'd5: dec_mode = M_ZPX;
                3'd7: dec_mode = M_ABX;
                default: dec_mode = M_IMP;
            endcase
            default: dec_mode = M_IMP;
        endcase

        special = 1'b1;
        dec_len = 3'd2;
        case (instruction)
            8'h00:                dec_len = 3'd7;
            8'h20, 8'h40, 8'h60:  dec_len = 3'd6;
            8'h08, 8'h48, 8'h4C:  dec_len = 3'd3;
            8'h28, 8'h68:         dec_len = 3'd4;
            8'h6C:                dec_len = 3'd5;
            default:              special = 1'b0;
        endcase
        if (special) dec_mode = M_STK;

        if (special || dec_mode == M_REL)
            dec_cls = C_CTRL;
        else if (cc != 2'b11 && aaa == 3'd4 &&
                 dec_mode != M_IMP && dec_mode != M_IMM)
            dec_cls = C_STORE;
        else if (cc == 2'b10 && aaa != 3'd4 && aaa != 3'd5 &&
                 (dec_mode == M_ZPG || dec_mode == M_ZPX ||
                  dec_mode == M_ABS || dec_mode == M_ABX))
            dec_cls = C_RMW;
        else
            dec_cls = C_READ;

        if (!special) begin
            case (dec_mode)
                M_ZPG:          dec_len = (dec_cls == C_RMW) ? 3'd5 : 3'd3;
                M_ZPX:          dec_len = (dec_cls == C_RMW) ? 3'd6 : 3'd4;
                M_ZPY:          dec_len = 3'd4;
                M_ABS:          dec_len = (dec_cls == C_RMW) ? 3'd6 : 3'd4;
                M_ABX:          dec_len = (dec_cls == C_RMW) ? 3'd7 :
                                          (dec_cls == C_STORE) ? 3'd5 : 3'd4;
                M_ABY:          dec_len = (dec_cls == C_STORE) ? 3'd5 : 3'd4;
                M_IZX:          dec_len = 3'd6;
                M_IZY:          dec_len = (dec_cls == C_STORE) ? 3'd6 : 3'd5;
                default:        dec_len = 3'd2;
            endcase
        end
    end

    // Penalty cycles stretch the running length in the cycle that samples them.
    always_comb begin
        penalty = 1'b0;
        if (op_class == C_READ && (addr_mode == M_ABX || addr_mode == M_ABY) &&
            t_state == T_WIDTH'(3))
            penalty = pc_eff;
        if (op_class == C_READ && addr_mode == M_IZY && t_state == T_WIDTH'(4))
            penalty = pc_eff;
        if (addr_mode == M_REL && t_state == T_WIDTH'(1))
            penalty = branch_taken;
        if (addr_mode == M_REL && t_state == T_WIDTH'(2))
            penalty = pc_eff;
    end
    assign len_eff = len_q + {2'b00, penalty};

    // Output decode
    always_comb begin
        sync       = (t_state == '0);
        last_cycle = !sync && (t_state == T_WIDTH'(len_eff - 3'd1));
        rw         = 1'b1;
        if (!sync) begin
            case (op_class)
                C_STORE: rw = !last_cycle;
                C_RMW:   rw = !(last_cycle || t_state == T_WIDTH'(len_eff - 3'd2));
                C_CTRL: case (opcode)
                    8'h08, 8'h48: rw = (t_state != T_WIDTH'(2));
                    8'h20:        rw = !(t_state == T_WIDTH'(3) || t_state == T_WIDTH'(4));
                    8'h00:        rw = !(t_state == T_WIDTH'(2) || t_state == T_WIDTH'(3) ||
                                         t_state == T_WIDTH'(4));
                    default:      rw = 1'b1;
                endcase
                default: rw = 1'b1;
            endcase
        end
    end

    assign stall = !rdy && (RDY_STALL_WRITES != 0 || rw);

    // Next-state
    always_comb begin
        t_n      = t_state;
        opcode_n = opcode;
        mode_n   = addr_mode;
        cls_n    = op_class;
        len_n    = len_q;
        if (!stall) begin
            if (sync) begin
                t_n      = T_WIDTH'(1);
                opcode_n = instruction;
                mode_n   = dec_mode;
                cls_n    = dec_cls;
                len_n    = dec_len;
            end else if (last_cycle) begin
                t_n   = '0;
                len_n = len_eff;
            end else begin
                t_n   = t_state + T_WIDTH'(1);
                len_n = len_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            t_state   <= '0;
            opcode    <= 8'hEA;
            addr_mode <= M_IMP;
            op_class  <= C_READ;
            len_q     <= 3'd2;
        end else begin
            t_state   <= t_n;
            opcode    <= opcode_n;
            addr_mode <= mode_n;
            op_class  <= cls_n;
            len_q     <= len_n;
        end
    end
endmodule
